// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in
//   the EX stage. It handles MULT, MULTU, DIV and DIVU. Multiplies use
//   iterative shift-add and divides use restoring division, one iteration per
//   cycle. The unit stalls the pipeline while it runs and writes the HI/LO
//   result registers.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     start        EX holds an R-type instruction this cycle
//     Function     funct field: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
//     op_a         rs operand (multiplicand / dividend)
//     op_b         rt operand (multiplier / divisor)
//     flush        squash the in-flight operation
//     busy         unit is not idle
//     stall        freeze the IF/ID/EX pipeline registers
//     done         one-cycle pulse: hi/lo hold the new result
//     hi, lo       product high/low, or remainder/quotient
//     div_by_zero  pulses with done when a divide had a zero divisor
//
//   State | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for an accepted MULT/MULTU/DIV/DIVU
//   RUN   | WIDTH iterations on magnitudes, counter 0..WIDTH-1
//   FIX   | sign correction, hi/lo written on the exit edge
//   DONE  | done pulse; pipeline released while results are valid
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Function,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_is_div;
    logic                 r_neg_res;   // product / quotient must be negated
    logic                 r_neg_rem;   // remainder takes the dividend's sign
    logic                 r_dz;
    logic [WIDTH-1:0]     r_m;         // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;       // mul: {partial, multiplier}; div: {rem, quo}
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_op_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // funct 0110xx: bit 1 selects divide, bit 0 selects unsigned
    assign w_accept = start & (r_state == S_IDLE) & ~flush & (Function[5:2] == 4'b0110);
    assign w_signed = ~Function[0];
    assign w_op_div = Function[1];

    assign w_a_neg = w_signed & op_a[WIDTH-1];
    assign w_b_neg = w_signed & op_b[WIDTH-1];
    assign w_mag_a = w_a_neg ? -op_a : op_a;
    assign w_mag_b = w_b_neg ? -op_b : op_b;

    // Shift-add step: the carry out of the add becomes the new top bit.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step. The shifted remainder needs WIDTH+1 bits, but once the
    // divisor fits the difference is below 2^WIDTH, so WIDTH bits suffice.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_m;
    assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_acc[WIDTH-1:0];
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

    // With a zero divisor every trial subtract succeeds, so the remainder half
    // ends up holding the dividend magnitude; restoring its sign yields the raw
    // dividend. The quotient is forced to all ones regardless of sign.
    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_rem ? -w_rem : w_rem;
            w_fix_lo = r_dz ? '1 : (r_neg_res ? -w_quo : w_quo);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_m       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div  <= w_op_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dz      <= w_op_div & (op_b == '0);
                        r_m       <= w_op_div ? w_mag_b : w_mag_a;
                        r_acc     <= {{WIDTH{1'b0}}, (w_op_div ? w_mag_a : w_mag_b)};
                        r_cnt     <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_dbz   <= r_dz;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    // The accept term is combinational so the accepting instruction is held in EX.
    assign stall       = (r_state == S_RUN) | (r_state == S_FIX) | w_accept;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer (WIDTH=32). The driver pushes the
//   expected hi/lo/div_by_zero and the completion cycle for every accepted
//   operation. An independent monitor pops and compares on every done pulse.
//   Expected values come from plain 64-bit signed/unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   Function;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Function    (Function),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the instruction means arithmetically.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int due);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        e.hi  = '0;
        e.lo  = '0;
        e.dbz = 1'b0;
        e.cyc = due;
        if (f == F_MULT) begin
            q    = sa * sbv;
            e.hi = q[63:32];
            e.lo = q[31:0];
        end else if (f == F_MULTU) begin
            p    = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
        end else if (f == F_DIV) begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end else begin
            e.hi = a % b;
            e.lo = a / b;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = W'($urandom_range(0, 15));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 with nothing outstanding, expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("done_cycle", 64'(mon_e.cyc == cyc ? mon_e.cyc : cyc), 64'(mon_e.cyc));
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("div_by_zero", div_by_zero, mon_e.dbz);
                cur_hi = mon_e.hi;
                cur_lo = mon_e.lo;
            end
        end else if (!reset && div_by_zero) begin
            tests++;
            fails++;
            $display("FAIL stray_div_by_zero: got 1 without done, expected 0 (cycle %0d)", cyc);
        end
    end

    // Issue one operation in an idle cycle and walk it through to DONE. Start
    // pulses while busy and start/flush in the DONE cycle must all be ignored.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b0;
        Function = f;
        op_a     = a;
        op_b     = b;
        #1;
        check("idle_before_accept", busy, 1'b0);
        check("accept_stall", stall, 1'b1);
        n = cyc;
        sbq.push_back(model(f, a, b, n + LAT));
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            Function = 6'($urandom_range(24, 27));
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            flush    = 1'b0;
            #1;
            check("run_stall", stall, 1'b1);
            if (k == 1 || k == LAT - 1) begin
                check("run_busy", busy, 1'b1);
                check("hold_hi", hi, cur_hi);
                check("hold_lo", lo, cur_lo);
            end
        end
        @(negedge clk);
        start    = 1'($urandom_range(0, 1));
        Function = 6'($urandom_range(24, 27));
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        flush    = 1'($urandom_range(0, 1));
        #1;
        check("done_busy", busy, 1'b1);
        check("done_stall", stall, 1'b0);
    endtask

    task automatic directed(input string name, input logic [5:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input logic edbz);
        run_op(f, a, b);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time 400000");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        Function = '0;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        directed("multu_7x6",   F_MULTU, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0);
        directed("mult_m3x5",   F_MULT,  32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        directed("multu_max",   F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,      1'b0);
        directed("div_m7d2",    F_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        directed("div_ovf",     F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,      32'h8000_0000, 1'b0);
        directed("divu_10d0",   F_DIVU,  32'd10,       32'd0,        32'hA,        32'hFFFF_FFFF, 1'b1);
        directed("div_m5d0",    F_DIV,   32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // Requests that must be ignored in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b0; Function = 6'b100000; op_a = 32'd1; op_b = 32'd2;
        #1;
        check("add_ignored_stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b1; flush = 1'b1; Function = F_MULT;
        #1;
        check("flush_start_stall", stall, 1'b0);
        check("add_ignored_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b1; flush = 1'b0; Function = 6'b011100;
        #1;
        check("flush_start_busy", busy, 1'b0);
        check("funct_011100_stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("funct_011100_busy", busy, 1'b0);

        // Flush mid-RUN keeps the previous result.
        directed("multu_3x4", F_MULTU, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0);
        @(negedge clk);
        start = 1'b1; flush = 1'b0; Function = F_DIVU; op_a = 32'd100; op_b = 32'd7;
        #1;
        n = cyc;
        check("flush_accept_stall", stall, 1'b1);
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_run_stall", stall, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flushed_busy", busy, 1'b0);
        check("flushed_stall", stall, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        check("flushed_hi", hi, 32'h0);
        check("flushed_lo", lo, 32'hC);

        for (int i = 0; i < 40; i++) begin
            run_op(6'($urandom_range(24, 27)), pick_op(), pick_op());
        end

        // Asynchronous reset in the middle of RUN.
        directed("multu_pre_rst", F_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
        @(negedge clk);
        start = 1'b1; flush = 1'b0; Function = F_MULT; op_a = W'($urandom); op_b = W'($urandom);
        #1;
        sbq.push_back(model(F_MULT, op_a, op_b, cyc + LAT));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_done", done, 1'b0);
        sbq.delete();
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op(F_DIVU, 32'd100, 32'd7);

        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
